pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards that forwarding cannot cover, taken-branch redirects, multi-cycle mul/div occupancy of EX, and data-memory wait states. It also keeps saturating stall/flush performance counters and a sticky mul/div timeout flag.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `MD_TIMEOUT`, default 64: maximum number of MD_WAIT cycles before a forced release (≥2).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `IF_ID_RS1_i`, `IF_ID_RS2_i` in 5: source registers of the instruction in ID.
- `IF_ID_RS1_used_i`, `IF_ID_RS2_used_i` in 1: the ID instruction actually reads RS1/RS2.
- `ID_EX_RD_i` in 5: destination of the instruction in EX.
- `ID_EX_MemRead_i` in 1: the EX instruction is a load.
- `EX_Branch_Taken_i` in 1: the EX instruction redirects the PC (branch taken or jump).
- `EX_MulDiv_Start_i` in 1: a mul/div instruction is in EX and starts this cycle.
- `MulDiv_Done_i` in 1: the mul/div result is valid this cycle.
- `dmem_req_i` in 1: the MEM stage issues a data-memory access.
- `dmem_ready_i` in 1: data memory completes the access this cycle.
- `PC_Write_o`, `IF_ID_Write_o`, `ID_EX_Write_o`, `EX_MEM_Write_o`, `MEM_WB_Write_o` out 1: register load enables.
- `IF_ID_Flush_o`, `ID_EX_Flush_o`, `EX_MEM_Flush_o`, `MEM_WB_Flush_o` out 1: register loads a bubble at the edge. Flush overrides Write.
- `state_o` out 2: FSM state, encoded RUN=0, MEM_WAIT=1, MD_WAIT=2.
- `stall_cnt_o` out CNT_W: number of cycles with `PC_Write_o`=0.
- `flush_cnt_o` out CNT_W: number of branch-flush cycles.
- `muldiv_timeout_o` out 1: sticky; set on a mul/div timeout.

## Operation
- **Outputs are combinational** from state and inputs. Default for every output: all Write=1, all Flush=0.
- **While `rst_i`=1:**
  - All Write=0 and all Flush=1.
  - At the edge: state←RUN, counters←0, `muldiv_timeout_o`←0, MD cycle counter←0.
- **Freeze patterns:**
  - MEMFRZ: PC/IF_ID/ID_EX/EX_MEM Write=0; `MEM_WB_Flush_o`=1.
  - MDFRZ: PC/IF_ID/ID_EX Write=0; `EX_MEM_Flush_o`=1; MEM_WB Write=1.
  - BR: `IF_ID_Flush_o`=1 and `ID_EX_Flush_o`=1; all Write=1.
  - LU: PC/IF_ID Write=0; `ID_EX_Flush_o`=1.
- **Load-use condition (lu):** `ID_EX_MemRead_i` && `ID_EX_RD_i`≠0 && ((RS1_used && RD==RS1) || (RS2_used && RD==RS2)).
- **RUN evaluation**, in priority order:
  1. `dmem_req_i`&&!`dmem_ready_i` → MEMFRZ; next state MEM_WAIT.
  2. `EX_MulDiv_Start_i` → MDFRZ; next state MD_WAIT; MD counter←1.
  3. `EX_Branch_Taken_i` → BR (branch beats lu, because the ID instruction is wrong-path).
  4. lu → LU.
  - In RUN, `MulDiv_Done_i` is ignored.
- **MEM_WAIT:**
  - While `dmem_ready_i`=0: MEMFRZ; stay in MEM_WAIT.
  - When `dmem_ready_i`=1: perform RUN evaluation with rule 1 skipped, including its next-state choice. A branch or mul/div held in EX during the wait is acted on in this cycle.
- **MD_WAIT:**
  - While `MulDiv_Done_i`=0 and MD counter < `MD_TIMEOUT`: MDFRZ; counter increments.
  - On `MulDiv_Done_i`=1: all Write=1, no Flush; next state RUN.
  - On MD counter = `MD_TIMEOUT` with no done: same release as done, and `muldiv_timeout_o`←1 (sticky until reset).
  - `dmem_req_i`, branch and lu are ignored in MD_WAIT. The EX instruction is the mul/div, and MEM holds bubbles.
- **Counters:**
  - `stall_cnt_o` += 1 on every non-reset cycle with `PC_Write_o`=0.
  - `flush_cnt_o` += 1 on every BR cycle.
  - Both saturate at 2^CNT_W−1.
- **Illegal state 3:** behaves as RUN; next state RUN.

## Timing
- Hazard response is in the same cycle (0 latency). State changes take effect on the next edge.
- **Load-use:** exactly 1 bubble cycle. On the next cycle the load has moved to MEM, lu is false, and the pipeline resumes.
- **Branch:** 2 bubbles (IF/ID and ID/EX flushed) in 1 cycle; the PC loads the target at the same edge.
- **Mul/div with done N cycles after start (N≥1):** MDFRZ for N cycles (start cycle plus N−1), release in the done cycle. PC is frozen for N cycles.
- **Memory wait:** freeze for every cycle in which ready=0; the stage advances at the edge where ready=1.
- **Reset mid-wait:** the next cycle is RUN with no residual stall, counters are 0, and the timeout flag is cleared.

## Test plan
- **Load-use:** ID_EX_MemRead=1, RD=5, RS1=5 (used) → PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for 1 cycle; stall_cnt 0→1. Repeat with RD=0 → no stall.
- **Branch vs load-use:** EX_Branch_Taken=1 together with lu → IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1; flush_cnt=1; stall_cnt unchanged.
- **Mul/div:** start at cycle 0, done at cycle 5 → state_o=2 in cycles 1–5; EX_MEM_Flush=1 in cycles 0–4; full enable at cycle 5; state_o=0 at cycle 6; stall_cnt=5.
- **Mul/div timeout:** MD_TIMEOUT=4, done never asserted → release after 4 MD cycles; muldiv_timeout_o=1 and holds until rst_i.
- **Memory wait:** dmem_req=1, ready=0 for 3 cycles, then 1 → MEM_WB_Flush=1 and all upstream Write=0 for 3 cycles; state_o=1; normal operation on the ready cycle. Assert EX_Branch_Taken throughout → BR only on the ready cycle.
- **Reset and saturation:** rst_i during MD_WAIT → next cycle state_o=0 with counters 0. With CNT_W=4, 20 stall cycles → stall_cnt=15.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - hazard status inputs and stage control outputs
//
// Groups every hazard-status signal and every pipeline-register control of
// pipeline_hazard_controller into one bundle.
//   master : pipeline side; drives hazard status, receives stage controls
//   slave  : hazard controller; receives hazard status, drives stage controls
// Signals:
//   IF_ID_RS1_i/IF_ID_RS2_i (5), IF_ID_RS1_used_i/IF_ID_RS2_used_i : ID sources
//   ID_EX_RD_i (5), ID_EX_MemRead_i                                 : EX destination / load
//   EX_Branch_Taken_i, EX_MulDiv_Start_i, MulDiv_Done_i             : EX events
//   dmem_req_i, dmem_ready_i                                        : data-memory handshake
//   *_Write_o, *_Flush_o                                            : stage load / bubble controls
//   state_o (2), stall_cnt_o/flush_cnt_o (CNT_W), muldiv_timeout_o  : status
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IF_ID_RS1_i;
    logic [4:0]       IF_ID_RS2_i;
    logic             IF_ID_RS1_used_i;
    logic             IF_ID_RS2_used_i;
    logic [4:0]       ID_EX_RD_i;
    logic             ID_EX_MemRead_i;
    logic             EX_Branch_Taken_i;
    logic             EX_MulDiv_Start_i;
    logic             MulDiv_Done_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;
    logic             PC_Write_o;
    logic             IF_ID_Write_o;
    logic             ID_EX_Write_o;
    logic             EX_MEM_Write_o;
    logic             MEM_WB_Write_o;
    logic             IF_ID_Flush_o;
    logic             ID_EX_Flush_o;
    logic             EX_MEM_Flush_o;
    logic             MEM_WB_Flush_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             muldiv_timeout_o;

    modport master (
        output IF_ID_RS1_i, IF_ID_RS2_i, IF_ID_RS1_used_i, IF_ID_RS2_used_i,
               ID_EX_RD_i, ID_EX_MemRead_i, EX_Branch_Taken_i, EX_MulDiv_Start_i,
               MulDiv_Done_i, dmem_req_i, dmem_ready_i,
        input  PC_Write_o, IF_ID_Write_o, ID_EX_Write_o, EX_MEM_Write_o, MEM_WB_Write_o,
               IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o, MEM_WB_Flush_o,
               state_o, stall_cnt_o, flush_cnt_o, muldiv_timeout_o
    );

    modport slave (
        input  IF_ID_RS1_i, IF_ID_RS2_i, IF_ID_RS1_used_i, IF_ID_RS2_used_i,
               ID_EX_RD_i, ID_EX_MemRead_i, EX_Branch_Taken_i, EX_MulDiv_Start_i,
               MulDiv_Done_i, dmem_req_i, dmem_ready_i,
        output PC_Write_o, IF_ID_Write_o, ID_EX_Write_o, EX_MEM_Write_o, MEM_WB_Write_o,
               IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o, MEM_WB_Flush_o,
               state_o, stall_cnt_o, flush_cnt_o, muldiv_timeout_o
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for the 5-stage RV32 pipeline
//
// Resolves load-use hazards, taken-branch redirects, mul/div occupancy of EX
// and data-memory wait states by driving the load-enable and bubble controls
// of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Controls are combinational from the
// current state and inputs; Flush overrides Write at each register.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   hz    : slave side of pipeline_hazard_controller_if (hazard status in,
//           stage controls, state, saturating counters and timeout flag out)
module pipeline_hazard_controller #(
    parameter int CNT_W      = 32,
    parameter int MD_TIMEOUT = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    pipeline_hazard_controller_if.slave     hz
);
    localparam int MD_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [MD_W-1:0] MD_LIMIT = MD_W'(MD_TIMEOUT);
    localparam logic [MD_W-1:0] MD_ONE   = MD_W'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MD_WAIT  = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [MD_W-1:0]  md_cnt;
    logic [MD_W-1:0]  md_cnt_n;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             timeout_flag;
    logic             timeout_set;
    logic             br_cycle;
    logic             lu;
    logic             mem_hold;

    logic pc_w, ifid_w, idex_w, exmem_w, memwb_w;
    logic ifid_f, idex_f, exmem_f, memwb_f;

    assign lu = hz.ID_EX_MemRead_i && (hz.ID_EX_RD_i != 5'd0) &&
                ((hz.IF_ID_RS1_used_i && (hz.ID_EX_RD_i == hz.IF_ID_RS1_i)) ||
                 (hz.IF_ID_RS2_used_i && (hz.ID_EX_RD_i == hz.IF_ID_RS2_i)));

    // Once in MEM_WAIT the request is already outstanding, so only ready matters.
    assign mem_hold = (state == ST_MEM_WAIT) ? !hz.dmem_ready_i
                                             : (hz.dmem_req_i && !hz.dmem_ready_i);

    always_comb begin
        pc_w        = 1'b1;
        ifid_w      = 1'b1;
        idex_w      = 1'b1;
        exmem_w     = 1'b1;
        memwb_w     = 1'b1;
        ifid_f      = 1'b0;
        idex_f      = 1'b0;
        exmem_f     = 1'b0;
        memwb_f     = 1'b0;
        state_n     = state;
        md_cnt_n    = md_cnt;
        timeout_set = 1'b0;
        br_cycle    = 1'b0;

        if (rst_i) begin
            pc_w     = 1'b0;
            ifid_w   = 1'b0;
            idex_w   = 1'b0;
            exmem_w  = 1'b0;
            memwb_w  = 1'b0;
            ifid_f   = 1'b1;
            idex_f   = 1'b1;
            exmem_f  = 1'b1;
            memwb_f  = 1'b1;
            state_n  = ST_RUN;
            md_cnt_n = '0;
        end else if (state == ST_MD_WAIT) begin
            // EX holds the mul/div; MEM/dmem, branch and load-use are irrelevant here.
            if (hz.MulDiv_Done_i) begin
                state_n = ST_RUN;
            end else if (md_cnt >= MD_LIMIT) begin
                state_n     = ST_RUN;
                timeout_set = 1'b1;
            end else begin
                pc_w     = 1'b0;
                ifid_w   = 1'b0;
                idex_w   = 1'b0;
                exmem_f  = 1'b1;
                md_cnt_n = md_cnt + MD_ONE;
            end
        end else if (mem_hold) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            memwb_f = 1'b1;
            state_n = ST_MEM_WAIT;
        end else if (hz.EX_MulDiv_Start_i) begin
            pc_w     = 1'b0;
            ifid_w   = 1'b0;
            idex_w   = 1'b0;
            exmem_f  = 1'b1;
            state_n  = ST_MD_WAIT;
            md_cnt_n = MD_ONE;
        end else begin
            // RUN, MEM_WAIT on its ready cycle, and the unused encoding all land here.
            state_n = ST_RUN;
            if (hz.EX_Branch_Taken_i) begin
                // The ID instruction is wrong-path, so its load-use hazard is moot.
                ifid_f   = 1'b1;
                idex_f   = 1'b1;
                br_cycle = 1'b1;
            end else if (lu) begin
                pc_w   = 1'b0;
                ifid_w = 1'b0;
                idex_f = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_RUN;
            md_cnt       <= '0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state  <= state_n;
            md_cnt <= md_cnt_n;
            if (!pc_w && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (br_cycle && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (timeout_set) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign hz.PC_Write_o       = pc_w;
    assign hz.IF_ID_Write_o    = ifid_w;
    assign hz.ID_EX_Write_o    = idex_w;
    assign hz.EX_MEM_Write_o   = exmem_w;
    assign hz.MEM_WB_Write_o   = memwb_w;
    assign hz.IF_ID_Flush_o    = ifid_f;
    assign hz.ID_EX_Flush_o    = idex_f;
    assign hz.EX_MEM_Flush_o   = exmem_f;
    assign hz.MEM_WB_Flush_o   = memwb_f;
    assign hz.state_o          = state;
    assign hz.stall_cnt_o      = stall_cnt;
    assign hz.flush_cnt_o      = flush_cnt;
    assign hz.muldiv_timeout_o = timeout_flag;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.CNT_W(32)) ifa ();
    pipeline_hazard_controller_if #(.CNT_W(4))  ifb ();

    pipeline_hazard_controller #(.CNT_W(32), .MD_TIMEOUT(64)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (ifa.slave)
    );

    pipeline_hazard_controller #(.CNT_W(4), .MD_TIMEOUT(4)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (ifb.slave)
    );

    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB} Write, then {IF_ID, ID_EX, EX_MEM, MEM_WB} Flush
    localparam logic [8:0] NORM   = 9'b11111_0000;
    localparam logic [8:0] RSTP   = 9'b00000_1111;
    localparam logic [8:0] MEMFRZ = 9'b00001_0001;
    localparam logic [8:0] MDFRZ  = 9'b00011_0010;
    localparam logic [8:0] BR     = 9'b11111_1100;
    localparam logic [8:0] LU     = 9'b00111_0100;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       ms;
        logic       dn;
        logic       rq;
        logic       ry;
    } stim_t;

    typedef struct {
        bit         sel;
        string      nm;
        logic [8:0] ctrl;
        logic [1:0] st;
        int         sc;
        int         fc;
        logic       to;
    } exp_t;

    exp_t  sb[$];
    stim_t s;
    int    n_vec  = 0;
    int    n_fail = 0;

    task automatic drive(input stim_t x);
        rst                   = x.rst;
        ifa.IF_ID_RS1_i       = x.rs1;  ifb.IF_ID_RS1_i       = x.rs1;
        ifa.IF_ID_RS2_i       = x.rs2;  ifb.IF_ID_RS2_i       = x.rs2;
        ifa.IF_ID_RS1_used_i  = x.u1;   ifb.IF_ID_RS1_used_i  = x.u1;
        ifa.IF_ID_RS2_used_i  = x.u2;   ifb.IF_ID_RS2_used_i  = x.u2;
        ifa.ID_EX_RD_i        = x.rd;   ifb.ID_EX_RD_i        = x.rd;
        ifa.ID_EX_MemRead_i   = x.mr;   ifb.ID_EX_MemRead_i   = x.mr;
        ifa.EX_Branch_Taken_i = x.br;   ifb.EX_Branch_Taken_i = x.br;
        ifa.EX_MulDiv_Start_i = x.ms;   ifb.EX_MulDiv_Start_i = x.ms;
        ifa.MulDiv_Done_i     = x.dn;   ifb.MulDiv_Done_i     = x.dn;
        ifa.dmem_req_i        = x.rq;   ifb.dmem_req_i        = x.rq;
        ifa.dmem_ready_i      = x.ry;   ifb.dmem_ready_i      = x.ry;
    endtask

    // Apply the current stimulus for one cycle without an expectation.
    task automatic d();
        drive(s);
        @(posedge clk);
        #1;
    endtask

    // Apply the current stimulus for one cycle and queue the expected response.
    task automatic v(input string nm, input bit sel, input logic [8:0] c,
                     input logic [1:0] st, input int sc, input int fc, input logic to);
        exp_t e;
        drive(s);
        e.sel = sel; e.nm = nm; e.ctrl = c; e.st = st; e.sc = sc; e.fc = fc; e.to = to;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so every cycle with a queued
    // expectation is compared at the falling edge.
    initial begin
        exp_t       e;
        logic [8:0] c;
        logic [1:0] st;
        int         sc;
        int         fc;
        logic       to;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    c  = {ifb.PC_Write_o, ifb.IF_ID_Write_o, ifb.ID_EX_Write_o, ifb.EX_MEM_Write_o,
                          ifb.MEM_WB_Write_o, ifb.IF_ID_Flush_o, ifb.ID_EX_Flush_o,
                          ifb.EX_MEM_Flush_o, ifb.MEM_WB_Flush_o};
                    st = ifb.state_o;
                    sc = int'(ifb.stall_cnt_o);
                    fc = int'(ifb.flush_cnt_o);
                    to = ifb.muldiv_timeout_o;
                end else begin
                    c  = {ifa.PC_Write_o, ifa.IF_ID_Write_o, ifa.ID_EX_Write_o, ifa.EX_MEM_Write_o,
                          ifa.MEM_WB_Write_o, ifa.IF_ID_Flush_o, ifa.ID_EX_Flush_o,
                          ifa.EX_MEM_Flush_o, ifa.MEM_WB_Flush_o};
                    st = ifa.state_o;
                    sc = int'(ifa.stall_cnt_o);
                    fc = int'(ifa.flush_cnt_o);
                    to = ifa.muldiv_timeout_o;
                end
                n_vec++;
                if (c !== e.ctrl || st !== e.st || sc != e.sc || fc != e.fc || to !== e.to) begin
                    n_fail++;
                    $display("FAIL %s (dut_%s): got ctrl=%b st=%0d stall=%0d flush=%0d to=%b, want ctrl=%b st=%0d stall=%0d flush=%0d to=%b",
                             e.nm, e.sel ? "b" : "a", c, st, sc, fc, to,
                             e.ctrl, e.st, e.sc, e.fc, e.to);
                end
            end
        end
    end

    initial begin
        s = '0;
        drive(s);
        @(posedge clk);
        #1;

        // Reset and load-use (dut_a)
        s = '0; s.rst = 1'b1;  d();
        v("reset", 0, RSTP, 2'd0, 0, 0, 1'b0);
        s = '0;                v("idle_after_reset", 0, NORM, 2'd0, 0, 0, 1'b0);
        s = '0; s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
        v("lu_rs1", 0, LU, 2'd0, 0, 0, 1'b0);
        s = '0;                v("lu_resume", 0, NORM, 2'd0, 1, 0, 1'b0);
        s = '0; s.mr = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
        v("lu_rd_zero", 0, NORM, 2'd0, 1, 0, 1'b0);
        s = '0; s.mr = 1; s.rd = 7; s.rs2 = 7; s.u2 = 0;
        v("lu_rs2_unused", 0, NORM, 2'd0, 1, 0, 1'b0);
        s.u2 = 1;              v("lu_rs2", 0, LU, 2'd0, 1, 0, 1'b0);
        s = '0;                v("lu_rs2_resume", 0, NORM, 2'd0, 2, 0, 1'b0);

        // Branch beats load-use
        s = '0; s.br = 1; s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
        v("br_over_lu", 0, BR, 2'd0, 2, 0, 1'b0);
        s = '0;                v("br_after", 0, NORM, 2'd0, 2, 1, 1'b0);

        // Mul/div, done 5 cycles after start; dmem/branch ignored while waiting
        s = '0; s.ms = 1;      v("md_c0", 0, MDFRZ, 2'd0, 2, 1, 1'b0);
        s = '0;                v("md_c1", 0, MDFRZ, 2'd2, 3, 1, 1'b0);
        s = '0; s.br = 1; s.rq = 1;
        v("md_c2_ignore", 0, MDFRZ, 2'd2, 4, 1, 1'b0);
        s = '0;                v("md_c3", 0, MDFRZ, 2'd2, 5, 1, 1'b0);
        v("md_c4", 0, MDFRZ, 2'd2, 6, 1, 1'b0);
        s = '0; s.dn = 1;      v("md_c5_done", 0, NORM, 2'd2, 7, 1, 1'b0);
        s = '0;                v("md_c6_run", 0, NORM, 2'd0, 7, 1, 1'b0);
        s = '0; s.dn = 1;      v("done_in_run", 0, NORM, 2'd0, 7, 1, 1'b0);

        // Memory wait with a branch held in EX
        s = '0; s.rq = 1; s.br = 1;
        v("mem_c0", 0, MEMFRZ, 2'd0, 7, 1, 1'b0);
        v("mem_c1", 0, MEMFRZ, 2'd1, 8, 1, 1'b0);
        v("mem_c2", 0, MEMFRZ, 2'd1, 9, 1, 1'b0);
        s.ry = 1;              v("mem_ready_br", 0, BR, 2'd1, 10, 1, 1'b0);
        s = '0;                v("mem_after", 0, NORM, 2'd0, 10, 2, 1'b0);

        // Memory wait releasing into a mul/div start
        s = '0; s.rq = 1; s.ms = 1;
        v("memmd_c0", 0, MEMFRZ, 2'd0, 10, 2, 1'b0);
        s.ry = 1;              v("memmd_ready", 0, MDFRZ, 2'd1, 11, 2, 1'b0);
        s = '0; s.dn = 1;      v("memmd_done", 0, NORM, 2'd2, 12, 2, 1'b0);
        s = '0;                v("memmd_run", 0, NORM, 2'd0, 12, 2, 1'b0);
        s = '0; s.rq = 1; s.ry = 1;
        v("mem_ready_same", 0, NORM, 2'd0, 12, 2, 1'b0);

        // Memory wait releasing into a load-use
        s = '0; s.rq = 1;      v("memlu_c0", 0, MEMFRZ, 2'd0, 12, 2, 1'b0);
        s.ry = 1; s.mr = 1; s.rd = 9; s.rs1 = 9; s.u1 = 1;
        v("memlu_ready", 0, LU, 2'd1, 13, 2, 1'b0);
        s = '0;                v("memlu_after", 0, NORM, 2'd0, 14, 2, 1'b0);

        // Reset in the middle of MD_WAIT
        s = '0; s.ms = 1;      v("rmd_c0", 0, MDFRZ, 2'd0, 14, 2, 1'b0);
        s = '0;                v("rmd_c1", 0, MDFRZ, 2'd2, 15, 2, 1'b0);
        s = '0; s.rst = 1;     v("rmd_reset", 0, RSTP, 2'd2, 16, 2, 1'b0);
        s = '0;                v("rmd_after", 0, NORM, 2'd0, 0, 0, 1'b0);

        // Mul/div timeout with MD_TIMEOUT=4 (dut_b)
        s = '0; s.rst = 1;     v("b_reset", 1, RSTP, 2'd0, 0, 0, 1'b0);
        s = '0; s.ms = 1;      v("to_c0", 1, MDFRZ, 2'd0, 0, 0, 1'b0);
        s = '0;                v("to_c1", 1, MDFRZ, 2'd2, 1, 0, 1'b0);
        v("to_c2", 1, MDFRZ, 2'd2, 2, 0, 1'b0);
        v("to_c3", 1, MDFRZ, 2'd2, 3, 0, 1'b0);
        v("to_c4_release", 1, NORM, 2'd2, 4, 0, 1'b0);
        v("to_c5_flag", 1, NORM, 2'd0, 4, 0, 1'b1);
        v("to_sticky", 1, NORM, 2'd0, 4, 0, 1'b1);
        s = '0; s.dn = 1;      v("to_sticky_done", 1, NORM, 2'd0, 4, 0, 1'b1);
        s = '0; s.br = 1;      v("to_sticky_br", 1, BR, 2'd0, 4, 0, 1'b1);
        s = '0;                v("to_sticky_after", 1, NORM, 2'd0, 4, 1, 1'b1);

        // Stall counter saturation with CNT_W=4
        s = '0; s.mr = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1;
        for (int i = 0; i < 20; i++) begin
            v($sformatf("sat_%0d", i), 1, LU, 2'd0, (4 + i > 15) ? 15 : 4 + i, 1, 1'b1);
        end
        s = '0;                v("sat_hold", 1, NORM, 2'd0, 15, 1, 1'b1);
        s = '0; s.rst = 1;     v("sat_reset", 1, RSTP, 2'd0, 15, 1, 1'b1);
        s = '0;                v("sat_cleared", 1, NORM, 2'd0, 0, 0, 1'b0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
